// File: rtl/pipe_pkg.sv
// Shared control-pipeline definitions: default field widths, stall-mode codes and the
// default-width control payload with its all-zero bubble constant.
package pipe_pkg;

   localparam int unsigned OP_W_DEF  = 5;
   localparam int unsigned REG_W_DEF = 5;
   localparam int unsigned F7_W_DEF  = 2;
   localparam int unsigned F3_W      = 3;

   localparam int unsigned STALL_BUBBLE = 0;
   localparam int unsigned STALL_HOLD   = 1;

   typedef struct packed {
      logic [OP_W_DEF-1:0]  op;
      logic [F3_W-1:0]      f3;
      logic [F7_W_DEF-1:0]  f7;
      logic [REG_W_DEF-1:0] rd;
      logic [REG_W_DEF-1:0] rs1;
      logic [REG_W_DEF-1:0] rs2;
   } ctrl_fields_t;

   localparam ctrl_fields_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear (clear wins over inc).
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Control-field pipeline register with flush/stall handling and stall-age hang detection.
// Optional bubble counter enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_stage
   import pipe_pkg::*;
#(
   parameter int unsigned OP_W       = 5,
   parameter int unsigned F7_W       = 2,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned STALL_MODE = 0,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned TIMEOUT    = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [OP_W-1:0]  in_op,
   input  logic [F3_W-1:0]  in_f3,
   input  logic [F7_W-1:0]  in_f7,
   input  logic [REG_W-1:0] in_rd,
   input  logic [REG_W-1:0] in_rs1,
   input  logic [REG_W-1:0] in_rs2,
   output logic             out_valid,
   output logic [OP_W-1:0]  out_op,
   output logic [F3_W-1:0]  out_f3,
   output logic [F7_W-1:0]  out_f7,
   output logic [REG_W-1:0] out_rd,
   output logic [REG_W-1:0] out_rs1,
   output logic [REG_W-1:0] out_rs2,
   output logic [CNT_W-1:0] stall_age,
   output logic             stall_timeout,
   output logic [31:0]      bubble_cnt
);

   localparam bit HOLD_MODE = (STALL_MODE == STALL_HOLD);

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [F3_W-1:0]  f3;
      logic [F7_W-1:0]  f7;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } fields_t;

   fields_t fields_q, fields_d;
   logic    valid_q, valid_d;
   logic    bubble_c;

   // Dead entries load all-zero fields so rd=0 can never hit writeback or forwarding.
   always_comb begin
      valid_d  = valid_q;
      fields_d = fields_q;
      bubble_c = 1'b0;
      if (flush || (stall && !HOLD_MODE) || (!stall && !in_valid)) begin
         bubble_c = 1'b1;
      end
      if (bubble_c) begin
         valid_d  = 1'b0;
         fields_d = '0;
      end else if (!stall) begin
         valid_d      = 1'b1;
         fields_d.op  = in_op;
         fields_d.f3  = in_f3;
         fields_d.f7  = in_f7;
         fields_d.rd  = in_rd;
         fields_d.rs1 = in_rs1;
         fields_d.rs2 = in_rs2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         fields_q <= '0;
      end else begin
         valid_q  <= valid_d;
         fields_q <= fields_d;
      end
   end

   assign out_valid = valid_q;
   assign out_op    = fields_q.op;
   assign out_f3    = fields_q.f3;
   assign out_f7    = fields_q.f7;
   assign out_rd    = fields_q.rd;
   assign out_rs1   = fields_q.rs1;
   assign out_rs2   = fields_q.rs2;

   // Flush does not reset the age: a stall still pending under a flush is still a stall.
   sat_counter #(.W(CNT_W)) u_stall_age (
      .clk   (clk),
      .rst   (rst),
      .clear (!stall),
      .inc   (stall),
      .count (stall_age)
   );

   assign stall_timeout = (stall_age >= CNT_W'(TIMEOUT));

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] bubble_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_q <= '0;
      end else if (bubble_c) begin
         bubble_q <= bubble_q + 32'd1;
      end
   end

   assign bubble_cnt = bubble_q;
`else
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Three instances (bubble mode, hold mode, short-timeout) driven by shared stimulus and
// compared every cycle against a rule-level reference model.
module tb_pipe_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_f3 = '0;
   logic [1:0]  in_f7 = '0;

   logic        ov_w  [3];
   logic [24:0] fld_w [3];
   logic [7:0]  age_w [3];
   logic        to_w  [3];
   logic [31:0] bub_w [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned CW = (g == 2) ? 3 : 8;
      localparam int unsigned TO = (g == 2) ? 4 : 200;
      localparam int unsigned SM = (g == 1) ? 1 : 0;
      logic [CW-1:0] age_l;
      logic [4:0]    op_l, rd_l, rs1_l, rs2_l;
      logic [2:0]    f3_l;
      logic [1:0]    f7_l;

      pipe_ctrl_stage #(
         .OP_W(5), .F7_W(2), .REG_W(5), .STALL_MODE(SM), .CNT_W(CW), .TIMEOUT(TO)
      ) u_dut (
         .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
         .in_op(in_op), .in_f3(in_f3), .in_f7(in_f7), .in_rd(in_rd), .in_rs1(in_rs1),
         .in_rs2(in_rs2), .out_valid(ov_w[g]), .out_op(op_l), .out_f3(f3_l), .out_f7(f7_l),
         .out_rd(rd_l), .out_rs1(rs1_l), .out_rs2(rs2_l), .stall_age(age_l),
         .stall_timeout(to_w[g]), .bubble_cnt(bub_w[g])
      );

      assign fld_w[g] = {op_l, f3_l, f7_l, rd_l, rs1_l, rs2_l};
      assign age_w[g] = 8'(age_l);
   end

   // Reference model state, one entry per instance.
   int          m_mode [3] = '{0, 1, 0};
   int          m_max  [3] = '{255, 255, 7};
   int          m_thr  [3] = '{200, 200, 4};
   logic        e_valid[3];
   logic [24:0] e_fld  [3];
   int          e_age  [3];
   logic [31:0] e_bub  [3];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         e_valid[i] = 1'b0; e_fld[i] = '0; e_age[i] = 0; e_bub[i] = '0;
      end
   endfunction

   function automatic void model_step();
      for (int i = 0; i < 3; i++) begin
         e_age[i] = stall ? ((e_age[i] < m_max[i]) ? e_age[i] + 1 : m_max[i]) : 0;
         if (flush || (stall && m_mode[i] == 0) || (!stall && !in_valid)) begin
            e_valid[i] = 1'b0; e_fld[i] = '0; e_bub[i] = e_bub[i] + 32'd1;
         end else if (!stall) begin
            e_valid[i] = 1'b1;
            e_fld[i]   = {in_op, in_f3, in_f7, in_rd, in_rs1, in_rs2};
         end
      end
   endfunction

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("d%0d_valid", i), 32'(ov_w[i]), 32'(e_valid[i]));
         check($sformatf("d%0d_fields", i), 32'(fld_w[i]), 32'(e_fld[i]));
         check($sformatf("d%0d_age", i), 32'(age_w[i]), 32'(e_age[i]));
         check($sformatf("d%0d_timeout", i), 32'(to_w[i]), 32'(e_age[i] >= m_thr[i]));
`ifdef PIPE_CTRL_PERF_CNT_EN
         check($sformatf("d%0d_bubbles", i), bub_w[i], e_bub[i]);
`else
         check($sformatf("d%0d_bubbles", i), bub_w[i], 32'd0);
`endif
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1 check_all();
   endtask

   task automatic drive(input logic st, input logic fl, input logic v, input logic [4:0] op,
                        input logic [2:0] f3, input logic [1:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      stall = st; flush = fl; in_valid = v; in_op = op; in_f3 = f3; in_f7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
   endtask

   task automatic drive_rand(input int p_stall, input int p_flush, input int p_valid);
      drive($urandom_range(0, 99) < p_stall, $urandom_range(0, 99) < p_flush,
            $urandom_range(0, 99) < p_valid, 5'($urandom), 3'($urandom), 2'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom));
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b1, 5'h0C, 3'd0, 2'd0, 5'd1, 5'd2, 5'd3);
      #2;
      apply_reset();
      cycle();
      check("reset_release_op", 32'(fld_w[0][24:20]), 32'h0C);

      // pass-through, then a dead entry
      drive(1'b0, 1'b0, 1'b1, 5'h0C, 3'b000, 2'b10, 5'd7, 5'd3, 5'd4);
      cycle();
      check("pass_rd", 32'(fld_w[0][14:10]), 32'd7);
      drive(1'b0, 1'b0, 1'b0, 5'h1F, 3'd7, 2'd3, 5'd9, 5'd9, 5'd9);
      cycle();

      // load rd=9, then three stalled edges with changing inputs
      drive(1'b0, 1'b0, 1'b1, 5'h04, 3'd1, 2'd1, 5'd9, 5'd5, 5'd6);
      cycle();
      for (int k = 0; k < 3; k++) begin
         drive_rand(100, 0, 100);
         cycle();
      end
      check("hold_rd", 32'(fld_w[1][14:10]), 32'd9);
      check("stall_age_3", 32'(age_w[0]), 32'd3);
      drive(1'b1, 1'b1, 1'b1, 5'h05, 3'd2, 2'd2, 5'd11, 5'd12, 5'd13);
      cycle();
      drive(1'b0, 1'b0, 1'b1, 5'h05, 3'd2, 2'd2, 5'd11, 5'd12, 5'd13);
      cycle();

      // 10-cycle stall saturates the short counter; 260 saturates the 8-bit one
      for (int k = 0; k < 10; k++) begin
         drive_rand(100, 20, 50);
         cycle();
      end
      check("sat_age_7", 32'(age_w[2]), 32'd7);
      drive(1'b0, 1'b0, 1'b1, 5'h01, 3'd0, 2'd0, 5'd1, 5'd1, 5'd1);
      cycle();
      for (int k = 0; k < 260; k++) begin
         drive_rand(100, 5, 50);
         cycle();
      end
      check("sat_age_255", 32'(age_w[0]), 32'd255);
      drive_rand(0, 0, 100);
      cycle();

      // 5 flushes + 2 dead entries + 3 hold-mode stalls from reset
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         drive_rand(0, 0, 100);
         if (k < 5) flush = 1'b1;
         else if (k < 7) in_valid = 1'b0;
         else stall = 1'b1;
         cycle();
      end
`ifdef PIPE_CTRL_PERF_CNT_EN
      check("bubble_cnt_7", bub_w[1], 32'd7);
`else
      check("bubble_cnt_0", bub_w[1], 32'd0);
`endif

      // randomized traffic with a mid-operation asynchronous reset
      for (int k = 0; k < 400; k++) begin
         drive_rand((k % 100 < 50) ? 30 : 90, 10, 70);
         cycle();
         if (k == 200) apply_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
